fifo_mst_io_reg: RTL and testbench



---
 rtl/fifo_mst_io_reg.sv | 162 ++++++++++++++++
 tb/tb_fifo_mst_io_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mst_io_reg.sv
// Registered pad stage between the FT60x FIFO-master bus and the internal FIFO master controller.
// Adds registered controls, an input synchroniser chain and a bus-direction FSM with turnaround gap.
module fifo_mst_io_reg #(
    parameter int  WIDTH_DATA = 32,
    parameter int  IN_STAGES  = 1,
    parameter int  TURN_GAP   = 1,
    localparam int CNT_BE     = WIDTH_DATA / 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    inout  wire  [WIDTH_DATA-1:0] DATA,
    inout  wire  [CNT_BE-1:0]     BE,
    input  logic                  TXE_N,
    input  logic                  RXF_N,
    output logic                  SIWU_N,
    output logic                  WR_N,
    output logic                  RD_N,
    output logic                  OE_N,
    input  logic [WIDTH_DATA-1:0] tp_data,
    input  logic [CNT_BE-1:0]     tp_be,
    input  logic                  tp_drv_req,
    input  logic                  tp_siwu_n,
    input  logic                  tp_wr_n,
    input  logic                  tp_rd_n,
    input  logic                  tp_oe_n,
    input  logic                  tp_conflict_clr,
    output logic [WIDTH_DATA-1:0] tc_data,
    output logic [CNT_BE-1:0]     tc_be,
    output logic                  tc_txe_n,
    output logic                  tc_rxf_n,
    output logic                  tc_drv_gnt,
    output logic                  tc_conflict
);

    localparam logic [1:0] GAP_LOAD = (TURN_GAP > 0) ? 2'(TURN_GAP - 1) : 2'd0;

    typedef enum logic [1:0] {
        BUS_IN  = 2'd0,
        BUS_GAP = 2'd1,
        BUS_OUT = 2'd2
    } bus_state_t;

    bus_state_t            state_r;
    logic [1:0]            gcnt_r;
    logic                  conflict_r;
    logic                  conflict_set_s;
    logic                  oe_blk_s;
    logic                  drv_s;
    logic [WIDTH_DATA-1:0] data_q_r;
    logic [CNT_BE-1:0]     be_q_r;
    logic [WIDTH_DATA-1:0] data_pipe_r [IN_STAGES];
    logic [CNT_BE-1:0]     be_pipe_r   [IN_STAGES];
    logic                  txe_pipe_r  [IN_STAGES];
    logic                  rxf_pipe_r  [IN_STAGES];

    // OE_N follows tp_oe_n by one edge, so looking at both covers "asserted or about to be".
    assign oe_blk_s    = (tp_oe_n == 1'b0) || (OE_N == 1'b0);
    assign drv_s       = (state_r == BUS_OUT);
    assign DATA        = drv_s ? data_q_r : {WIDTH_DATA{1'bz}};
    assign BE          = drv_s ? be_q_r : {CNT_BE{1'bz}};
    assign tc_drv_gnt  = drv_s;
    assign tc_conflict = conflict_r;
    assign tc_data     = data_pipe_r[IN_STAGES-1];
    assign tc_be       = be_pipe_r[IN_STAGES-1];
    assign tc_txe_n    = txe_pipe_r[IN_STAGES-1];
    assign tc_rxf_n    = rxf_pipe_r[IN_STAGES-1];

    // Conflict condition for the current state.
    always_comb begin
        conflict_set_s = 1'b0;
        case (state_r)
            BUS_IN, BUS_GAP: conflict_set_s = tp_drv_req && oe_blk_s;
            BUS_OUT:         conflict_set_s = (tp_oe_n == 1'b0);
            default:         conflict_set_s = 1'b0;
        endcase
    end

    // Registered control pads and outgoing data/BE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SIWU_N   <= 1'b1;
            WR_N     <= 1'b1;
            RD_N     <= 1'b1;
            OE_N     <= 1'b1;
            data_q_r <= {WIDTH_DATA{1'b0}};
            be_q_r   <= {CNT_BE{1'b0}};
        end else begin
            SIWU_N   <= tp_siwu_n;
            WR_N     <= tp_wr_n;
            RD_N     <= tp_rd_n;
            OE_N     <= tp_oe_n;
            data_q_r <= tp_data;
            be_q_r   <= tp_be;
        end
    end

    // Input synchroniser chains on DATA, BE and the FIFO flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < IN_STAGES; i++) begin
                data_pipe_r[i] <= {WIDTH_DATA{1'b0}};
                be_pipe_r[i]   <= {CNT_BE{1'b0}};
                txe_pipe_r[i]  <= 1'b1;
                rxf_pipe_r[i]  <= 1'b1;
            end
        end else begin
            data_pipe_r[0] <= DATA;
            be_pipe_r[0]   <= BE;
            txe_pipe_r[0]  <= TXE_N;
            rxf_pipe_r[0]  <= RXF_N;
            for (int i = 1; i < IN_STAGES; i++) begin
                data_pipe_r[i] <= data_pipe_r[i-1];
                be_pipe_r[i]   <= be_pipe_r[i-1];
                txe_pipe_r[i]  <= txe_pipe_r[i-1];
                rxf_pipe_r[i]  <= rxf_pipe_r[i-1];
            end
        end
    end

    // Bus-direction FSM with turnaround gap and sticky conflict flag (set beats clear).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= BUS_IN;
            gcnt_r     <= 2'd0;
            conflict_r <= 1'b0;
        end else begin
            case (state_r)
                BUS_IN: begin
                    if (tp_drv_req && !oe_blk_s) begin
                        if (TURN_GAP == 0) begin
                            state_r <= BUS_OUT;
                        end else begin
                            state_r <= BUS_GAP;
                            gcnt_r  <= GAP_LOAD;
                        end
                    end
                end
                BUS_GAP: begin
                    if (!tp_drv_req || oe_blk_s) begin
                        state_r <= BUS_IN;
                    end else if (gcnt_r == 2'd0) begin
                        state_r <= BUS_OUT;
                    end else begin
                        gcnt_r <= gcnt_r - 2'd1;
                    end
                end
                BUS_OUT: begin
                    if (!tp_drv_req || (tp_oe_n == 1'b0)) begin
                        state_r <= BUS_IN;
                    end
                end
                default: state_r <= BUS_IN;
            endcase
            if (conflict_set_s) begin
                conflict_r <= 1'b1;
            end else if (tp_conflict_clr) begin
                conflict_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_mst_io_reg.sv
// Directed bench for fifo_mst_io_reg: instance A (32-bit, 1 input stage, gap 2) and
// instance B (16-bit, 3 input stages, gap 0), checked against a queue of expected values.
module tb_fifo_mst_io_reg;

    localparam int GAP_A = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A signals
    wire  [31:0] data_a;
    wire  [3:0]  be_a;
    logic        ft_drv_a;
    logic [31:0] ft_data_a;
    logic [3:0]  ft_be_a;
    logic        txe_a, rxf_a, siwu_a, wr_a, rd_a, oe_a;
    logic [31:0] tp_data_a;
    logic [3:0]  tp_be_a;
    logic        tp_req_a, tp_siwu_a, tp_wr_a, tp_rd_a, tp_oe_a, tp_clr_a;
    logic [31:0] tc_data_a;
    logic [3:0]  tc_be_a;
    logic        tc_txe_a, tc_rxf_a, gnt_a, conf_a;

    // Instance B signals
    wire  [15:0] data_b;
    wire  [1:0]  be_b;
    logic        ft_drv_b;
    logic [15:0] ft_data_b;
    logic [1:0]  ft_be_b;
    logic        txe_b, rxf_b, siwu_b, wr_b, rd_b, oe_b;
    logic [15:0] tp_data_b;
    logic [1:0]  tp_be_b;
    logic        tp_req_b, tp_siwu_b, tp_wr_b, tp_rd_b, tp_oe_b, tp_clr_b;
    logic [15:0] tc_data_b;
    logic [1:0]  tc_be_b;
    logic        tc_txe_b, tc_rxf_b, gnt_b, conf_b;

    // FT60x side of the bus
    assign data_a = ft_drv_a ? ft_data_a : 32'bz;
    assign be_a   = ft_drv_a ? ft_be_a : 4'bz;
    assign data_b = ft_drv_b ? ft_data_b : 16'bz;
    assign be_b   = ft_drv_b ? ft_be_b : 2'bz;

    fifo_mst_io_reg #(.WIDTH_DATA(32), .IN_STAGES(1), .TURN_GAP(GAP_A)) u_dut_a (
        .CLK(clk), .RESET(reset), .DATA(data_a), .BE(be_a),
        .TXE_N(txe_a), .RXF_N(rxf_a),
        .SIWU_N(siwu_a), .WR_N(wr_a), .RD_N(rd_a), .OE_N(oe_a),
        .tp_data(tp_data_a), .tp_be(tp_be_a), .tp_drv_req(tp_req_a),
        .tp_siwu_n(tp_siwu_a), .tp_wr_n(tp_wr_a), .tp_rd_n(tp_rd_a), .tp_oe_n(tp_oe_a),
        .tp_conflict_clr(tp_clr_a),
        .tc_data(tc_data_a), .tc_be(tc_be_a), .tc_txe_n(tc_txe_a), .tc_rxf_n(tc_rxf_a),
        .tc_drv_gnt(gnt_a), .tc_conflict(conf_a)
    );

    fifo_mst_io_reg #(.WIDTH_DATA(16), .IN_STAGES(3), .TURN_GAP(0)) u_dut_b (
        .CLK(clk), .RESET(reset), .DATA(data_b), .BE(be_b),
        .TXE_N(txe_b), .RXF_N(rxf_b),
        .SIWU_N(siwu_b), .WR_N(wr_b), .RD_N(rd_b), .OE_N(oe_b),
        .tp_data(tp_data_b), .tp_be(tp_be_b), .tp_drv_req(tp_req_b),
        .tp_siwu_n(tp_siwu_b), .tp_wr_n(tp_wr_b), .tp_rd_n(tp_rd_b), .tp_oe_n(tp_oe_b),
        .tp_conflict_clr(tp_clr_b),
        .tc_data(tc_data_b), .tc_be(tc_be_b), .tc_txe_n(tc_txe_b), .tc_rxf_n(tc_rxf_b),
        .tc_drv_gnt(gnt_b), .tc_conflict(conf_b)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance to the next falling edge; the pads must never drive while OE_N is low.
    task automatic cyc();
        @(negedge clk);
        chk("no_contention_a", {63'd0, gnt_a & ~oe_a}, 64'd0);
        chk("no_contention_b", {63'd0, gnt_b & ~oe_b}, 64'd0);
    endtask

    task automatic idle();
        tp_req_a = 1'b0; tp_siwu_a = 1'b1; tp_wr_a = 1'b1; tp_rd_a = 1'b1; tp_oe_a = 1'b1;
        tp_clr_a = 1'b0; ft_drv_a = 1'b0; txe_a = 1'b1; rxf_a = 1'b1;
        tp_req_b = 1'b0; tp_siwu_b = 1'b1; tp_wr_b = 1'b1; tp_rd_b = 1'b1; tp_oe_b = 1'b1;
        tp_clr_b = 1'b0; ft_drv_b = 1'b0; txe_b = 1'b1; rxf_b = 1'b1;
    endtask

    initial begin
        // Reset for two edges with random controller inputs
        reset = 1'b1;
        ft_drv_a = 1'b0; ft_data_a = 32'd0; ft_be_a = 4'd0;
        ft_drv_b = 1'b0; ft_data_b = 16'd0; ft_be_b = 2'd0;
        tp_data_a = $urandom; tp_be_a = 4'($urandom); tp_req_a = 1'($urandom);
        tp_siwu_a = 1'($urandom); tp_wr_a = 1'($urandom); tp_rd_a = 1'($urandom);
        tp_oe_a = 1'($urandom); tp_clr_a = 1'($urandom);
        txe_a = 1'($urandom); rxf_a = 1'($urandom);
        tp_data_b = 16'($urandom); tp_be_b = 2'($urandom); tp_req_b = 1'($urandom);
        tp_siwu_b = 1'($urandom); tp_wr_b = 1'($urandom); tp_rd_b = 1'($urandom);
        tp_oe_b = 1'($urandom); tp_clr_b = 1'($urandom);
        txe_b = 1'($urandom); rxf_b = 1'($urandom);
        cyc();
        cyc();
        chk("rst_ctrl_a", {60'd0, siwu_a, wr_a, rd_a, oe_a}, 64'hF);
        chk("rst_gnt_a", {63'd0, gnt_a}, 64'd0);
        chk("rst_conf_a", {63'd0, conf_a}, 64'd0);
        chk("rst_flags_a", {62'd0, tc_txe_a, tc_rxf_a}, 64'h3);
        chk("rst_tcdata_a", {28'd0, tc_be_a, tc_data_a}, 64'd0);
        chk("rst_ctrl_b", {60'd0, siwu_b, wr_b, rd_b, oe_b}, 64'hF);
        chk("rst_gnt_b", {63'd0, gnt_b}, 64'd0);
        chk("rst_flags_b", {62'd0, tc_txe_b, tc_rxf_b}, 64'h3);
        chk("rst_conf_b", {63'd0, conf_b}, 64'd0);

        reset = 1'b0;
        idle();
        cyc();

        // Control pads follow tp_* after one edge
        tp_wr_a = 1'b0; tp_siwu_a = 1'b0;
        cyc();
        chk("ctrl_a_0", {60'd0, siwu_a, wr_a, rd_a, oe_a}, 64'h3);
        tp_wr_a = 1'b1; tp_siwu_a = 1'b1; tp_rd_a = 1'b0; tp_oe_a = 1'b0;
        cyc();
        chk("ctrl_a_1", {60'd0, siwu_a, wr_a, rd_a, oe_a}, 64'hC);
        idle();
        cyc();

        // Drive with gap 2: request at j=0, driven from j=3 carrying previous-cycle data
        for (int k = 0; k < 12; k++) begin
            tp_req_a  = (k < 8);
            tp_data_a = 32'hA5A5_0001 + 32'(k);
            tp_be_a   = 4'(k) ^ 4'hA;
            sb_q.push_back({28'd0, tp_be_a, tp_data_a});
            cyc();
            exp_v = sb_q.pop_front();
            chk("drv_gnt_a", {63'd0, gnt_a}, {63'd0, ((k + 1) >= (1 + GAP_A)) && ((k + 1) <= 8)});
            if (((k + 1) >= (1 + GAP_A)) && ((k + 1) <= 8)) begin
                chk("drv_bus_a", {28'd0, be_a, data_a}, exp_v);
            end
        end

        // New request pays the gap again, then a forced release by tp_oe_n
        tp_req_a = 1'b1;
        cyc(); chk("b2b_gap1_a", {63'd0, gnt_a}, 64'd0);
        cyc(); chk("b2b_gap2_a", {63'd0, gnt_a}, 64'd0);
        cyc(); chk("b2b_out_a", {63'd0, gnt_a}, 64'd1);
        tp_oe_a = 1'b0;
        cyc();
        chk("force_gnt_a", {63'd0, gnt_a}, 64'd0);
        chk("force_oe_a", {63'd0, oe_a}, 64'd0);
        chk("force_conf_a", {63'd0, conf_a}, 64'd1);

        // Conflict in BUS_IN: set beats clear, clear alone drops it
        tp_clr_a = 1'b1;
        cyc(); chk("set_over_clr_a", {62'd0, conf_a, gnt_a}, 64'h2);
        tp_req_a = 1'b0;
        cyc(); chk("clr_a", {63'd0, conf_a}, 64'd0);
        tp_req_a = 1'b1; tp_clr_a = 1'b0;
        cyc(); chk("in_conf_a", {62'd0, conf_a, gnt_a}, 64'h2);
        tp_req_a = 1'b0; tp_clr_a = 1'b1;
        cyc(); chk("clr2_a", {63'd0, conf_a}, 64'd0);

        // Blocked by registered OE_N alone while tp_oe_n is already high
        tp_oe_a = 1'b1; tp_req_a = 1'b1; tp_clr_a = 1'b0;
        cyc(); chk("oe_pad_blk_a", {61'd0, conf_a, gnt_a, oe_a}, 64'h5);
        tp_req_a = 1'b0; tp_clr_a = 1'b1;
        cyc(); chk("clr3_a", {63'd0, conf_a}, 64'd0);
        tp_clr_a = 1'b0;

        // Request withdrawn during the gap: never driven, no conflict
        tp_req_a = 1'b1;
        cyc();
        tp_req_a = 1'b0;
        cyc(); chk("withdraw_gnt_a", {63'd0, gnt_a}, 64'd0);
        cyc(); chk("withdraw_a", {62'd0, conf_a, gnt_a}, 64'd0);

        // OE asserted during the gap: back to BUS_IN with conflict
        tp_req_a = 1'b1;
        cyc();
        tp_oe_a = 1'b0;
        cyc(); chk("gap_oe_a", {62'd0, conf_a, gnt_a}, 64'h2);
        tp_oe_a = 1'b1; tp_req_a = 1'b0; tp_clr_a = 1'b1;
        cyc(); chk("clr4_a", {63'd0, conf_a}, 64'd0);
        tp_clr_a = 1'b0;

        // Reset mid-drive releases the bus; the next drive pays the full gap
        tp_req_a = 1'b1;
        cyc(); cyc(); cyc();
        chk("pre_rst_gnt_a", {63'd0, gnt_a}, 64'd1);
        reset = 1'b1;
        cyc();
        chk("mid_rst_a", {58'd0, siwu_a, wr_a, rd_a, oe_a, conf_a, gnt_a}, 64'h3C);
        reset = 1'b0;
        cyc(); chk("post_rst_gap1_a", {63'd0, gnt_a}, 64'd0);
        cyc(); chk("post_rst_gap2_a", {63'd0, gnt_a}, 64'd0);
        cyc(); chk("post_rst_out_a", {63'd0, gnt_a}, 64'd1);
        tp_req_a = 1'b0;
        cyc(); chk("post_rst_rel_a", {63'd0, gnt_a}, 64'd0);

        // Read capture on B through three input stages
        for (int k = 0; k < 8; k++) begin
            ft_drv_b  = 1'b1;
            ft_data_b = 16'h1234 + 16'(k);
            ft_be_b   = 2'(k);
            txe_b     = k[0];
            rxf_b     = ~k[1];
            sb_q.push_back({44'd0, txe_b, rxf_b, ft_be_b, ft_data_b});
            cyc();
            if (k >= 2) begin
                exp_v = sb_q.pop_front();
                chk("capture_b", {44'd0, tc_txe_b, tc_rxf_b, tc_be_b, tc_data_b}, exp_v);
            end
        end
        sb_q.delete();
        ft_drv_b = 1'b0; txe_b = 1'b1; rxf_b = 1'b1;
        cyc();

        // Gap 0 on B: driven on the very next cycle, released the cycle after
        tp_req_b = 1'b1; tp_data_b = 16'hBEEF; tp_be_b = 2'b10;
        sb_q.push_back({46'd0, tp_be_b, tp_data_b});
        cyc();
        exp_v = sb_q.pop_front();
        chk("gap0_gnt_b", {63'd0, gnt_b}, 64'd1);
        chk("gap0_bus_b", {46'd0, be_b, data_b}, exp_v);
        tp_req_b = 1'b0;
        cyc();
        chk("gap0_rel_b", {62'd0, conf_b, gnt_b}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
